// File: rtl/pipelined_ksa.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipelined_ksa
// Description : Parametrised Kogge-Stone adder/subtractor with pipeline
//               registers between prefix levels and valid/ready flow control.
//               One global advance enable moves every stage together.
// Revision    : 1.0  initial release
// ============================================================================
module pipelined_ksa #(
   parameter int WIDTH         = 15,
   parameter int LVL_PER_STAGE = 2
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             Cin,
   input  logic             SUB,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH:0]   S,
   output logic             OVF
);

   // Prefix depth, stage count and number of inter-stage register banks
   localparam int c_L    = $clog2(WIDTH);
   localparam int c_N    = (c_L + LVL_PER_STAGE - 1) / LVL_PER_STAGE;
   localparam int c_NREG = (c_N > 1) ? (c_N - 1) : 1;

   logic             w_adv;
   logic [WIDTH-1:0] w_yy;
   logic [WIDTH-1:0] w_g0;
   logic [WIDTH-1:0] w_p0;
   logic             w_c0;

   // Prefix level outputs; index 0 is the raw generate/propagate vector
   logic [WIDTH-1:0] w_gl [0:c_L];
   logic [WIDTH-1:0] w_pl [0:c_L];

   // Inter-stage registers (bank j sits after prefix level (j+1)*LVL_PER_STAGE)
   logic [WIDTH-1:0]  r_g  [0:c_NREG-1];
   logic [WIDTH-1:0]  r_p  [0:c_NREG-1];
   logic [WIDTH-1:0]  r_p0 [0:c_NREG-1];
   logic [c_NREG-1:0] r_c0;
   logic [c_NREG-1:0] r_v;

   // Final stage inputs and result
   logic [WIDTH-1:0] w_fp0;
   logic             w_fc0;
   logic             w_fv;
   logic [WIDTH:0]   w_carry;
   logic [WIDTH:0]   w_sum;
   logic             w_ovf;

   logic             r_out_valid;
   logic [WIDTH:0]   r_s;
   logic             r_ovf;

   // Whole pipeline moves only when the output slot is free or being drained
   assign w_adv    = OUT_READY | ~r_out_valid;
   assign IN_READY = w_adv;

   // Subtraction is X + ~Y + 1, so Cin is ignored in that mode
   assign w_yy = SUB ? ~Y : Y;
   assign w_c0 = SUB | Cin;
   assign w_g0 = X & w_yy;
   assign w_p0 = X ^ w_yy;

   assign w_gl[0] = w_g0;
   assign w_pl[0] = w_p0;

   for (genvar k = 1; k <= c_L; k++) begin : g_lvl
      localparam int c_SPAN = 1 << (k - 1);
      logic [WIDTH-1:0] w_gi;
      logic [WIDTH-1:0] w_pi;
      logic [WIDTH-1:0] w_go;
      logic [WIDTH-1:0] w_po;

      // First level of a later stage takes its operands from the stage register
      if ((k > 1) && (((k - 1) % LVL_PER_STAGE) == 0)) begin : g_from_reg
         assign w_gi = r_g[((k - 1) / LVL_PER_STAGE) - 1];
         assign w_pi = r_p[((k - 1) / LVL_PER_STAGE) - 1];
      end else begin : g_from_comb
         assign w_gi = w_gl[k - 1];
         assign w_pi = w_pl[k - 1];
      end

      // One Kogge-Stone combine step; low bits below the span pass through
      always_comb begin
         w_go = w_gi;
         w_po = w_pi;
         for (int i = c_SPAN; i < WIDTH; i++) begin
            w_go[i] = w_gi[i] | (w_pi[i] & w_gi[i - c_SPAN]);
            w_po[i] = w_pi[i] & w_pi[i - c_SPAN];
         end
      end

      assign w_gl[k] = w_go;
      assign w_pl[k] = w_po;
   end

   if (c_N > 1) begin : g_pipe
      // Stage valid bits: cleared by reset, shifted on every advance
      always_ff @(posedge CLK) begin
         if (!RSTn) begin
            r_v <= '0;
         end else if (w_adv) begin
            r_v[0] <= IN_VALID;
            for (int j = 1; j < c_NREG; j++) begin
               r_v[j] <= r_v[j - 1];
            end
         end
      end

      // Stage data: prefix state plus P0/c0 needed for the final sum
      always_ff @(posedge CLK) begin
         if (w_adv) begin
            r_p0[0] <= w_p0;
            r_c0[0] <= w_c0;
            for (int j = 1; j < c_NREG; j++) begin
               r_p0[j] <= r_p0[j - 1];
               r_c0[j] <= r_c0[j - 1];
            end
            for (int j = 0; j < c_NREG; j++) begin
               r_g[j] <= w_gl[(j + 1) * LVL_PER_STAGE];
               r_p[j] <= w_pl[(j + 1) * LVL_PER_STAGE];
            end
         end
      end

      assign w_fp0 = r_p0[c_N - 2];
      assign w_fc0 = r_c0[c_N - 2];
      assign w_fv  = r_v[c_N - 2];
   end else begin : g_nopipe
      assign r_v   = '0;
      assign r_c0  = '0;
      assign r_g   = '{default: '0};
      assign r_p   = '{default: '0};
      assign r_p0  = '{default: '0};
      assign w_fp0 = w_p0;
      assign w_fc0 = w_c0;
      assign w_fv  = IN_VALID;
   end

   // Carries from the complete group (G,P) of bits [i:0] and the carry-in
   always_comb begin
      w_carry    = '0;
      w_carry[0] = w_fc0;
      for (int i = 0; i < WIDTH; i++) begin
         w_carry[i + 1] = w_gl[c_L][i] | (w_pl[c_L][i] & w_fc0);
      end
      w_sum = {w_carry[WIDTH], w_fp0 ^ w_carry[WIDTH-1:0]};
      w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];
   end

   // Output register: result only loads on a valid beat so bubbles leave S alone
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_out_valid <= 1'b0;
         r_s         <= '0;
         r_ovf       <= 1'b0;
      end else if (w_adv) begin
         r_out_valid <= w_fv;
         if (w_fv) begin
            r_s   <= w_sum;
            r_ovf <= w_ovf;
         end
      end
   end

   assign OUT_VALID = r_out_valid;
   assign S         = r_s;
   assign OVF       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_ksa.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_ksa
// Description : Scoreboard bench for pipelined_ksa at default parameters.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipelined_ksa;

   localparam int WIDTH         = 15;
   localparam int LVL_PER_STAGE = 2;
   localparam int c_N           = 2;

   logic             CLK = 1'b0;
   logic             RSTn;
   logic             IN_VALID;
   logic             IN_READY;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic             Cin;
   logic             SUB;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [WIDTH:0]   S;
   logic             OVF;

   typedef struct {
      logic [WIDTH:0] s;
      logic           ovf;
      int             acc;
      bit             chk;
   } exp_t;

   typedef struct {
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      logic             cin;
      logic             sub;
      logic [WIDTH:0]   s;
      logic             ovf;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[13];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   bit   bp_done = 1'b0;

   pipelined_ksa #(
      .WIDTH         (WIDTH),
      .LVL_PER_STAGE (LVL_PER_STAGE)
   ) dut (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .X         (X),
      .Y         (Y),
      .Cin       (Cin),
      .SUB       (SUB),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .S         (S),
      .OVF       (OVF)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Reference for the random phase: plain wide addition
   function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic cin, input logic sub);
      logic [WIDTH-1:0] yy;
      logic             c0;
      logic [WIDTH:0]   sum;
      exp_t             e;
      yy    = sub ? ~y : y;
      c0    = sub ? 1'b1 : cin;
      sum   = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, c0};
      e.s   = sum;
      e.ovf = (x[WIDTH-1] == yy[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
      e.acc = 0;
      e.chk = 1'b0;
      return e;
   endfunction

   // Present one beat; called #1 after a rising edge, returns #1 after the accept edge
   task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic cin, input logic sub,
                       input logic [WIDTH:0] es, input logic eo, input bit chk);
      int   waited;
      bit   done;
      exp_t e;
      waited   = 0;
      done     = 1'b0;
      X        = x;
      Y        = y;
      Cin      = cin;
      SUB      = sub;
      IN_VALID = 1'b1;
      while (!done) begin
         @(negedge CLK);
         if (IN_READY) begin
            e.s   = es;
            e.ovf = eo;
            e.acc = cyc;
            e.chk = chk;
            sb.push_back(e);
            done  = 1'b1;
         end else begin
            waited++;
            if (waited > 200) begin
               n_tests++;
               n_fail++;
               $display("FAIL accept_timeout: IN_READY=%0b after %0d cycles, required 1", IN_READY, waited);
               done = 1'b1;
            end
         end
         @(posedge CLK);
         #1;
      end
      IN_VALID = 1'b0;
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (sb.size() != 0 && waited < 200) begin
         @(posedge CLK);
         #1;
         waited++;
      end
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      end
      repeat (3) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Monitor: pops the scoreboard whenever a result is consumed
   initial begin : monitor
      bit             prev_stall;
      logic [WIDTH:0] prev_s;
      logic           prev_ovf;
      exp_t           e;
      prev_stall = 1'b0;
      prev_s     = '0;
      prev_ovf   = 1'b0;
      forever begin
         @(negedge CLK);
         if (!RSTn) begin
            prev_stall = 1'b0;
         end else begin
            n_tests++;
            if (IN_READY !== !(OUT_VALID && !OUT_READY)) begin
               n_fail++;
               $display("FAIL in_ready: got %0b, required %0b (OUT_VALID=%0b OUT_READY=%0b)",
                        IN_READY, !(OUT_VALID && !OUT_READY), OUT_VALID, OUT_READY);
            end
            if (prev_stall) begin
               n_tests++;
               if (S !== prev_s || OVF !== prev_ovf) begin
                  n_fail++;
                  $display("FAIL stall_hold: S=%h OVF=%0b, required S=%h OVF=%0b", S, OVF, prev_s, prev_ovf);
               end
            end
            if (OUT_VALID && OUT_READY) begin
               n_tests++;
               if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_output: S=%h OVF=%0b, required no output", S, OVF);
               end else begin
                  e = sb.pop_front();
                  if (S !== e.s || OVF !== e.ovf) begin
                     n_fail++;
                     $display("FAIL result: S=%h OVF=%0b, required S=%h OVF=%0b", S, OVF, e.s, e.ovf);
                  end
                  if (e.chk) begin
                     n_tests++;
                     if ((cyc - e.acc) != c_N) begin
                        n_fail++;
                        $display("FAIL latency: got %0d cycles, required %0d", cyc - e.acc, c_N);
                     end
                  end
               end
            end
            prev_stall = OUT_VALID && !OUT_READY;
            prev_s     = S;
            prev_ovf   = OVF;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [WIDTH-1:0] rx;
      logic [WIDTH-1:0] ry;
      logic             rc;
      logic             rs;
      exp_t             m;

      vecs[0]  = '{15'h7FFF, 15'h0001, 1'b0, 1'b0, 16'h8000, 1'b0};
      vecs[1]  = '{15'h7FFF, 15'h7FFF, 1'b1, 1'b0, 16'hFFFF, 1'b0};
      vecs[2]  = '{15'h0005, 15'h0007, 1'b0, 1'b1, 16'h7FFE, 1'b0};
      vecs[3]  = '{15'h0007, 15'h0005, 1'b0, 1'b1, 16'h8002, 1'b0};
      vecs[4]  = '{15'h4000, 15'h0001, 1'b0, 1'b1, 16'hBFFF, 1'b1};
      vecs[5]  = '{15'h3FFF, 15'h0001, 1'b0, 1'b0, 16'h4000, 1'b1};
      vecs[6]  = '{15'h4000, 15'h4000, 1'b0, 1'b0, 16'h8000, 1'b1};
      vecs[7]  = '{15'h0000, 15'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
      vecs[8]  = '{15'h0000, 15'h0000, 1'b1, 1'b1, 16'h8000, 1'b0};
      vecs[9]  = '{15'h7FFF, 15'h0001, 1'b1, 1'b0, 16'h8001, 1'b0};
      vecs[10] = '{15'h0000, 15'h4000, 1'b0, 1'b1, 16'h4000, 1'b1};
      vecs[11] = '{15'h7FFF, 15'h7FFF, 1'b0, 1'b0, 16'hFFFE, 1'b0};
      vecs[12] = '{15'h2AAA, 15'h1555, 1'b0, 1'b0, 16'h3FFF, 1'b0};

      RSTn      = 1'b0;
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      X         = '0;
      Y         = '0;
      Cin       = 1'b0;
      SUB       = 1'b0;
      repeat (3) @(posedge CLK);
      #1;

      // Reset state, observed while reset is still held
      @(negedge CLK);
      n_tests++;
      if (OUT_VALID !== 1'b0 || S !== '0 || OVF !== 1'b0 || IN_READY !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: OUT_VALID=%0b S=%h OVF=%0b IN_READY=%0b, required 0 0 0 1",
                  OUT_VALID, S, OVF, IN_READY);
      end
      @(posedge CLK);
      #1;
      RSTn = 1'b1;
      @(posedge CLK);
      #1;

      // Directed vectors, isolated then back-to-back
      for (int i = 0; i < 13; i++) begin
         send(vecs[i].x, vecs[i].y, vecs[i].cin, vecs[i].sub, vecs[i].s, vecs[i].ovf, 1'b1);
         repeat (2) begin
            @(posedge CLK);
            #1;
         end
      end
      for (int i = 0; i < 13; i++) begin
         send(vecs[i].x, vecs[i].y, vecs[i].cin, vecs[i].sub, vecs[i].s, vecs[i].ovf, 1'b1);
      end
      drain();

      // Backpressure: random beats against a randomly toggling consumer
      bp_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 24; i++) begin
               rx = WIDTH'($urandom);
               ry = WIDTH'($urandom);
               rc = 1'($urandom_range(0, 1));
               rs = 1'($urandom_range(0, 1));
               m  = model(rx, ry, rc, rs);
               send(rx, ry, rc, rs, m.s, m.ovf, 1'b0);
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge CLK);
                  #1;
               end
            end
            bp_done = 1'b1;
         end
         begin
            while (!bp_done) begin
               @(posedge CLK);
               #1;
               OUT_READY = 1'($urandom_range(0, 1));
            end
         end
      join
      OUT_READY = 1'b1;
      drain();

      // Reset with two beats in flight and a beat presented during reset
      OUT_READY = 1'b0;
      send(15'h0011, 15'h0022, 1'b0, 1'b0, 16'h0033, 1'b0, 1'b0);
      send(15'h0100, 15'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0);
      RSTn     = 1'b0;
      X        = 15'h1234;
      Y        = 15'h0001;
      Cin      = 1'b0;
      SUB      = 1'b0;
      IN_VALID = 1'b1;
      @(posedge CLK);
      #1;
      RSTn      = 1'b1;
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      sb.delete();
      @(negedge CLK);
      n_tests++;
      if (OUT_VALID !== 1'b0 || S !== '0 || OVF !== 1'b0 || IN_READY !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset: OUT_VALID=%0b S=%h OVF=%0b IN_READY=%0b, required 0 0 0 1",
                  OUT_VALID, S, OVF, IN_READY);
      end
      @(posedge CLK);
      #1;
      send(15'h0001, 15'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b1);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipelined_ksa.md
# pipelined_ksa

Parametrised, pipelined Kogge-Stone adder/subtractor with valid/ready flow control. Successor to the fixed 15-bit combinational Kogge-Stone adder: the operand width is generic, the carry-in is external, subtraction and signed overflow are supported, and pipeline registers can be placed between prefix levels. Sits in arithmetic datapaths as a drop-in two-operand adder wherever the critical path or throughput needs it.

## Interface
- WIDTH, 15, operand width in bits, ≥2.
- LVL_PER_STAGE, 2, prefix levels per pipeline stage, ≥1. L = ceil(log2(WIDTH)) prefix levels; stage count N = ceil(L/LVL_PER_STAGE).

- CLK  in  1  clock, all state on its rising edge.
- RSTn  in  1  reset, synchronous and active-low.
- IN_VALID  in  1  operand beat valid.
- IN_READY  out  1  block accepts a beat this cycle.
- X  in  WIDTH  operand 1.
- Y  in  WIDTH  operand 2.
- Cin  in  1  carry-in, used in add mode only.
- SUB  in  1  0: S = X+Y+Cin; 1: S = X−Y (Y inverted, carry-in forced 1, Cin ignored).
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts the result.
- S  out  WIDTH+1  result; S[WIDTH] is carry-out (add) or NOT-borrow (sub).
- OVF  out  1  two's-complement signed overflow of the WIDTH-bit result.

## Operation
- GP generation: G0[i] = X[i] & Y'[i], P0[i] = X[i] ^ Y'[i], where Y' = SUB ? ~Y : Y and c0 = SUB ? 1 : Cin.
- Prefix level k (1..L), span 2^(k−1): for i ≥ span, (G,P)k[i] = (Gk−1[i] | Pk−1[i]&Gk−1[i−span], Pk−1[i]&Pk−1[i−span]); for i < span, pass through.
- Carry into bit i+1: GL[i] | (PL[i] & c0). S[0] = P0[0]^c0. S[i] = carry_i ^ P0[i]. S[WIDTH] = carry out of bit WIDTH−1.
- OVF = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
- Pipeline: register after prefix levels LVL_PER_STAGE, 2·LVL_PER_STAGE, … strictly below L. The final stage computes the sum and registers S/OVF/OUT_VALID. Registered state per stage: current (G,P) vector, P0, c0, and stage valid bit. X, Y, SUB, and Cin are not needed past stage 1.
- Flow control: single global advance enable, adv = OUT_READY | ~OUT_VALID. IN_READY = adv (combinational).
  - When adv = 1, every stage shifts forward, and stage 1 loads the input with valid = IN_VALID & IN_READY.
  - When adv = 0, every stage holds, including valid bits and data.
- Bubbles are not collapsed. An empty stage still costs a cycle.
- A beat is transferred on an edge with IN_VALID & IN_READY. A result is consumed on an edge with OUT_VALID & OUT_READY.
- Arithmetic is modulo 2^(WIDTH+1) in S. Wrap-around (for example all-ones + 1) is required behaviour, not an error.

## Timing
- Latency: a beat accepted at edge t appears with OUT_VALID = 1 after edge t+N−1, provided no stall occurred. For the defaults (L=4, N=2), the result is visible in the cycle after the edge following acceptance. With LVL_PER_STAGE ≥ L, N = 1.
- Throughput: one beat per cycle while OUT_READY = 1.
- A stall of k cycles delays every in-flight beat by exactly k cycles. No beat is lost, duplicated, or reordered.
- Simultaneous consume and accept on the same edge is legal and sustains full rate.
- Reset: when RSTn = 0 on an edge, all stage valid bits clear.
  - OUT_VALID = 0, S = 0, OVF = 0 after that edge.
  - IN_READY = 1 during and after reset, since OUT_VALID = 0.
  - Data registers other than the output may be left uninitialised.
- Reset mid-operation discards all in-flight beats. A beat presented in the same cycle as reset is dropped.
- Output stability: while OUT_VALID & ~OUT_READY, S and OVF hold constant.

## Test plan
- Defaults, add: X=0x7FFF, Y=0x0001, Cin=0 → S=0x8000, OVF=0, OUT_VALID exactly N=2 cycles after accept; Cin=1 on X=Y=0x7FFF → S=0xFFFF.
- Subtract: SUB=1, X=5, Y=7 → S=0x07FFE (S[15]=0, borrow), OVF=0; X=7, Y=5 → S=0x08002, OVF=0; X=0x4000, Y=1 → S=0x0BFFF, OVF=1.
- Signed overflow, add: X=0x3FFF, Y=0x0001 → S=0x04000, OVF=1; X=0x4000, Y=0x4000 → S=0x08000, OVF=1.
- Backpressure: stream 8 random beats with OUT_READY toggling pseudo-randomly → output order and values match a reference model. IN_READY=0 exactly when OUT_VALID=1 and OUT_READY=0. S is stable during stalls.
- Reset mid-stream: assert RSTn=0 for one edge with 2 beats in flight → next cycle OUT_VALID=0, S=0. The first post-reset beat X=1, Y=2 → S=3 after N cycles, with no stale output.
- Parameter sweep: WIDTH ∈ {2, 15, 16, 33, 64} × LVL_PER_STAGE ∈ {1, 2, L}, 10k random add/sub beats each → bit-exact against X+Y+Cin / X−Y, latency = ceil(L/LVL_PER_STAGE).
